// File: rtl/mem_map_pkg.sv
// Shared types and default memory map for the CPU memory-bus router.
package mem_map_pkg;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned BE_W   = 4;

    typedef enum logic [1:0] {
        RESP_OK       = 2'd0,
        RESP_DECODE   = 2'd1,
        RESP_MISALIGN = 2'd2,
        RESP_TIMEOUT  = 2'd3
    } resp_err_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_RESP
    } state_t;

    // Payload driven onto the shared target bus
    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic              we;
        logic [BE_W-1:0]   be;
    } dev_req_t;

    localparam logic [31:0] NVM_BASE     = 32'h0000_0400;
    localparam logic [31:0] NVM_SIZE     = 32'h0037_FC00;
    localparam logic [31:0] BRAM_BASE    = 32'h0038_0400;
    localparam logic [31:0] BRAM_SIZE    = 32'h0001_9000;
    localparam logic [31:0] MMIO_BASE    = 32'h0038_0000;
    localparam logic [31:0] MMIO_SIZE    = 32'h0000_0400;
    localparam logic [31:0] BOOTROM_BASE = 32'h0000_0000;
    localparam logic [31:0] BOOTROM_SIZE = 32'h0000_0400;

    // Region i occupies bits [32*i +: 32]; region 0 is the lowest slice
    localparam logic [127:0] DEFAULT_REGION_BASE = {BOOTROM_BASE, MMIO_BASE, BRAM_BASE, NVM_BASE};
    localparam logic [127:0] DEFAULT_REGION_SIZE = {BOOTROM_SIZE, MMIO_SIZE, BRAM_SIZE, NVM_SIZE};

endpackage

// File: rtl/mem_bus_router_if.sv
// CPU-side and target-side handshake bundle of the memory-bus router.
interface mem_bus_router_if #(
    parameter int unsigned NUM_REGIONS = 4
);
    import mem_map_pkg::*;

    logic                          in_req_valid;
    logic                          out_req_ready;
    logic [ADDR_W-1:0]             in_address;
    logic [DATA_W-1:0]             in_write_data;
    logic                          in_write_en;
    logic [BE_W-1:0]               in_byte_en;
    logic                          out_resp_valid;
    logic                          in_resp_ready;
    logic [DATA_W-1:0]             out_resp_data;
    logic [1:0]                    out_resp_error;
    logic [NUM_REGIONS-1:0]        out_dev_req_valid;
    logic [NUM_REGIONS-1:0]        in_dev_req_ready;
    logic [ADDR_W-1:0]             out_dev_address;
    logic [DATA_W-1:0]             out_dev_write_data;
    logic                          out_dev_write_en;
    logic [BE_W-1:0]               out_dev_byte_en;
    logic [NUM_REGIONS-1:0]        in_dev_resp_valid;
    logic [DATA_W*NUM_REGIONS-1:0] in_dev_read_data;

    modport slave (
        input  in_req_valid, in_address, in_write_data, in_write_en, in_byte_en,
               in_resp_ready, in_dev_req_ready, in_dev_resp_valid, in_dev_read_data,
        output out_req_ready, out_resp_valid, out_resp_data, out_resp_error,
               out_dev_req_valid, out_dev_address, out_dev_write_data,
               out_dev_write_en, out_dev_byte_en
    );

    modport master (
        output in_req_valid, in_address, in_write_data, in_write_en, in_byte_en,
               in_resp_ready, in_dev_req_ready, in_dev_resp_valid, in_dev_read_data,
        input  out_req_ready, out_resp_valid, out_resp_data, out_resp_error,
               out_dev_req_valid, out_dev_address, out_dev_write_data,
               out_dev_write_en, out_dev_byte_en
    );

endinterface

// File: rtl/mem_region_decoder.sv
// Combinational region decode: one-hot hit (lowest index wins) and word offset.
module mem_region_decoder #(
    parameter int unsigned                NUM_REGIONS = 4,
    parameter logic [32*NUM_REGIONS-1:0]  REGION_BASE = '0,
    parameter logic [32*NUM_REGIONS-1:0]  REGION_SIZE = '0
) (
    input  logic [31:0]            address,
    output logic [NUM_REGIONS-1:0] hit_vec_c,
    output logic                   hit_c,
    output logic [31:0]            word_offset_c
);

    logic [NUM_REGIONS-1:0] hit_raw;
    logic [32:0]            diff [NUM_REGIONS];

    // 33-bit subtract: no borrow means addr >= base, and regions may end at 2^32
    for (genvar g = 0; g < NUM_REGIONS; g++) begin : g_region
        localparam logic [32:0] LO = {1'b0, REGION_BASE[32*g +: 32]};
        localparam logic [32:0] SZ = {1'b0, REGION_SIZE[32*g +: 32]};
        assign diff[g]    = {1'b0, address} - LO;
        assign hit_raw[g] = !diff[g][32] && (diff[g] < SZ);
    end

    always_comb begin
        hit_vec_c     = '0;
        word_offset_c = '0;
        hit_c         = |hit_raw;
        for (int i = NUM_REGIONS - 1; i >= 0; i--) begin
            if (hit_raw[i]) begin
                hit_vec_c     = '0;
                hit_vec_c[i]  = 1'b1;
                word_offset_c = {2'b00, diff[i][31:2]};
            end
        end
    end

endmodule

// File: rtl/mem_bus_router.sv
// Single-outstanding CPU memory-bus router with region decode and error completion.
// Optional target timeout enabled by defining MEM_BUS_ROUTER_TIMEOUT_EN.
module mem_bus_router
    import mem_map_pkg::*;
#(
    parameter int unsigned               NUM_REGIONS    = 4,
    parameter logic [32*NUM_REGIONS-1:0] REGION_BASE    = (32*NUM_REGIONS)'(DEFAULT_REGION_BASE),
    parameter logic [32*NUM_REGIONS-1:0] REGION_SIZE    = (32*NUM_REGIONS)'(DEFAULT_REGION_SIZE),
    parameter int unsigned               TIMEOUT_CYCLES = 256
) (
    input  logic             in_clk,
    input  logic             in_rst_n,
    mem_bus_router_if.slave  bus
);

    if (NUM_REGIONS < 1 || NUM_REGIONS > 8) begin : g_bad_regions
        $error("mem_bus_router: NUM_REGIONS must be 1..8");
    end
    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("mem_bus_router: TIMEOUT_CYCLES must be at least 1");
    end

    state_t                 state_q, state_d;
    logic [NUM_REGIONS-1:0] sel_q, sel_d;
    logic [NUM_REGIONS-1:0] strobe_q, strobe_d;
    dev_req_t               dev_q, dev_d;
    logic                   req_ready_q, req_ready_d;
    logic                   resp_valid_q, resp_valid_d;
    logic [DATA_W-1:0]      resp_data_q, resp_data_d;
    resp_err_t              resp_err_q, resp_err_d;

    logic [NUM_REGIONS-1:0] hit_vec_c;
    logic                   hit_c;
    logic [31:0]            word_offset_c;
    logic [DATA_W-1:0]      sel_rdata_c;
    logic                   sel_ready_c;
    logic                   sel_resp_c;

`ifdef MEM_BUS_ROUTER_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

    mem_region_decoder #(
        .NUM_REGIONS (NUM_REGIONS),
        .REGION_BASE (REGION_BASE),
        .REGION_SIZE (REGION_SIZE)
    ) u_decoder (
        .address       (bus.in_address),
        .hit_vec_c     (hit_vec_c),
        .hit_c         (hit_c),
        .word_offset_c (word_offset_c)
    );

    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            state_q      <= ST_IDLE;
            sel_q        <= '0;
            strobe_q     <= '0;
            dev_q        <= '0;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_data_q  <= '0;
            resp_err_q   <= RESP_OK;
`ifdef MEM_BUS_ROUTER_TIMEOUT_EN
            cnt_q        <= '0;
`endif
        end else begin
            state_q      <= state_d;
            sel_q        <= sel_d;
            strobe_q     <= strobe_d;
            dev_q        <= dev_d;
            req_ready_q  <= req_ready_d;
            resp_valid_q <= resp_valid_d;
            resp_data_q  <= resp_data_d;
            resp_err_q   <= resp_err_d;
`ifdef MEM_BUS_ROUTER_TIMEOUT_EN
            cnt_q        <= cnt_d;
`endif
        end
    end

    always_comb begin
        state_d      = state_q;
        sel_d        = sel_q;
        strobe_d     = strobe_q;
        dev_d        = dev_q;
        req_ready_d  = req_ready_q;
        resp_valid_d = resp_valid_q;
        resp_data_d  = resp_data_q;
        resp_err_d   = resp_err_q;
`ifdef MEM_BUS_ROUTER_TIMEOUT_EN
        cnt_d        = cnt_q;
`endif

        sel_rdata_c = '0;
        for (int i = 0; i < NUM_REGIONS; i++) begin
            if (sel_q[i]) sel_rdata_c = bus.in_dev_read_data[32*i +: 32];
        end
        sel_ready_c = |(strobe_q & bus.in_dev_req_ready);
        sel_resp_c  = |(sel_q & bus.in_dev_resp_valid);

        case (state_q)
            ST_IDLE: begin
                if (bus.in_req_valid) begin
                    req_ready_d = 1'b0;
                    if (bus.in_address[1:0] != 2'b00) begin
                        state_d      = ST_RESP;
                        resp_valid_d = 1'b1;
                        resp_data_d  = '0;
                        resp_err_d   = RESP_MISALIGN;
                    end else if (!hit_c) begin
                        state_d      = ST_RESP;
                        resp_valid_d = 1'b1;
                        resp_data_d  = '0;
                        resp_err_d   = RESP_DECODE;
                    end else begin
                        state_d     = ST_ISSUE;
                        sel_d       = hit_vec_c;
                        strobe_d    = hit_vec_c;
                        dev_d.addr  = word_offset_c;
                        dev_d.wdata = bus.in_write_data;
                        dev_d.we    = bus.in_write_en;
                        dev_d.be    = bus.in_byte_en;
`ifdef MEM_BUS_ROUTER_TIMEOUT_EN
                        cnt_d       = '0;
`endif
                    end
                end
            end
            ST_ISSUE: begin
                if (sel_ready_c) begin
                    state_d  = ST_WAIT;
                    strobe_d = '0;
                end
            end
            ST_WAIT: begin
                if (sel_resp_c) begin
                    state_d      = ST_RESP;
                    resp_valid_d = 1'b1;
                    resp_data_d  = dev_q.we ? '0 : sel_rdata_c;
                    resp_err_d   = RESP_OK;
                    sel_d        = '0;
                    dev_d        = '0;
                end
            end
            ST_RESP: begin
                if (bus.in_resp_ready) begin
                    state_d      = ST_IDLE;
                    resp_valid_d = 1'b0;
                    resp_data_d  = '0;
                    resp_err_d   = RESP_OK;
                    req_ready_d  = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

`ifdef MEM_BUS_ROUTER_TIMEOUT_EN
        // Abort a stalled target; a completion in the same cycle still wins
        if (state_q == ST_ISSUE || state_q == ST_WAIT) begin
            cnt_d = cnt_q + CNT_W'(1);
            if (state_d != ST_RESP && cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                state_d      = ST_RESP;
                strobe_d     = '0;
                sel_d        = '0;
                dev_d        = '0;
                resp_valid_d = 1'b1;
                resp_data_d  = '0;
                resp_err_d   = RESP_TIMEOUT;
            end
        end
`endif
    end

    assign bus.out_req_ready      = req_ready_q;
    assign bus.out_resp_valid     = resp_valid_q;
    assign bus.out_resp_data      = resp_data_q;
    assign bus.out_resp_error     = resp_err_q;
    assign bus.out_dev_req_valid  = strobe_q;
    assign bus.out_dev_address    = dev_q.addr;
    assign bus.out_dev_write_data = dev_q.wdata;
    assign bus.out_dev_write_en   = dev_q.we;
    assign bus.out_dev_byte_en    = dev_q.be;

endmodule

// File: tb/tb_mem_bus_router.sv
// Self-checking bench for mem_bus_router: directed scenarios plus randomized traffic.
module tb_mem_bus_router;

    localparam int unsigned NR  = 4;
    localparam int unsigned TMO = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    longint ref_base [NR] = '{64'h0000_0400, 64'h0038_0400, 64'h0038_0000, 64'h0000_0000};
    longint ref_size [NR] = '{64'h0037_FC00, 64'h0001_9000, 64'h0000_0400, 64'h0000_0400};

    always #5 clk = ~clk;

    mem_bus_router_if #(.NUM_REGIONS(NR)) bus ();

    mem_bus_router #(
        .NUM_REGIONS    (NR),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .in_clk   (clk),
        .in_rst_n (rst_n),
        .bus      (bus)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic int ref_region(input logic [31:0] a);
        longint aa;
        aa = {32'd0, a};
        for (int i = 0; i < NR; i++)
            if (aa >= ref_base[i] && aa < ref_base[i] + ref_size[i]) return i;
        return -1;
    endfunction

    function automatic logic [31:0] pick_addr();
        int     k;
        int     r;
        longint b;
        longint s;
        k = int'($urandom_range(0, 9));
        r = int'($urandom_range(0, NR - 1));
        b = ref_base[r];
        s = ref_size[r];
        case (k)
            5:       return 32'(b);
            6:       return 32'(b + s - 4);
            7:       return 32'(b + s);
            8:       return 32'(b + longint'($urandom_range(0, 255)) * 4 + longint'($urandom_range(1, 3)));
            9:       return $urandom;
            default: return 32'(b + (longint'($urandom) % (s / 4)) * 4);
        endcase
    endfunction

    task automatic idle_inputs();
        bus.in_req_valid      = 1'b0;
        bus.in_address        = '0;
        bus.in_write_data     = '0;
        bus.in_write_en       = 1'b0;
        bus.in_byte_en        = '0;
        bus.in_resp_ready     = 1'b0;
        bus.in_dev_req_ready  = '0;
        bus.in_dev_resp_valid = '0;
        bus.in_dev_read_data  = '0;
    endtask

    // One full transaction; called at posedge+1 with the router idle.
    task automatic run_txn(input logic [31:0] a, input logic we, input logic [31:0] wd,
                           input logic [3:0] be, input int rdy_lat, input int rsp_lat,
                           input logic [31:0] rd, input int hold);
        int              r;
        int              n;
        bit              ok;
        logic [1:0]      exp_err;
        logic [31:0]     exp_data;
        logic [31:0]     exp_off;
        logic [NR-1:0]   onehot;
        logic [32*NR-1:0] rdall;
        r = ref_region(a);
        exp_err  = (a[1:0] != 2'b00) ? 2'd2 : (r < 0) ? 2'd1 : 2'd0;
        exp_data = (exp_err == 2'd0 && !we) ? rd : 32'd0;
        chk("idle_req_ready", 32'(bus.out_req_ready), 32'd1);
        bus.in_req_valid  = 1'b1;
        bus.in_address    = a;
        bus.in_write_en   = we;
        bus.in_write_data = wd;
        bus.in_byte_en    = be;
        @(posedge clk); #1;
        n = 1;
        bus.in_req_valid = 1'b0;
        chk("busy_req_ready", 32'(bus.out_req_ready), 32'd0);
        if (exp_err != 2'd0) begin
            chk("err_resp_valid", 32'(bus.out_resp_valid), 32'd1);
            chk("err_no_strobe", 32'(bus.out_dev_req_valid), 32'd0);
        end else begin
            onehot  = NR'(1) << r;
            exp_off = 32'(({32'd0, a} - ref_base[r]) >> 2);
            chk("issue_strobe", 32'(bus.out_dev_req_valid), 32'(onehot));
            chk("issue_addr", bus.out_dev_address, exp_off);
            chk("issue_wdata", bus.out_dev_write_data, wd);
            chk("issue_we_be", {27'd0, bus.out_dev_write_en, bus.out_dev_byte_en}, {27'd0, we, be});
            ok = 1'b1;
            for (int k = 0; k < rdy_lat; k++) begin
                bus.in_dev_req_ready = ~onehot & NR'($urandom);
                @(posedge clk); #1;
                n++;
                if (bus.out_dev_req_valid !== onehot || bus.out_resp_valid !== 1'b0) ok = 1'b0;
            end
            chk("issue_hold", 32'(ok), 32'd1);
            bus.in_dev_req_ready = onehot;
            @(posedge clk); #1;
            n++;
            bus.in_dev_req_ready = '0;
            chk("wait_strobe_low", 32'(bus.out_dev_req_valid), 32'd0);
            chk("wait_addr", bus.out_dev_address, exp_off);
            ok = 1'b1;
            for (int k = 0; k < rsp_lat; k++) begin
                bus.in_dev_resp_valid = ~onehot & NR'($urandom);
                bus.in_dev_read_data  = {$urandom, $urandom, $urandom, $urandom};
                @(posedge clk); #1;
                n++;
                if (bus.out_resp_valid !== 1'b0) ok = 1'b0;
            end
            chk("wait_ignore_others", 32'(ok), 32'd1);
            rdall = {$urandom, $urandom, $urandom, $urandom};
            rdall[32*r +: 32] = rd;
            bus.in_dev_read_data  = rdall;
            bus.in_dev_resp_valid = onehot;
            @(posedge clk); #1;
            n++;
            bus.in_dev_resp_valid = '0;
            chk("ok_latency", 32'(n), 32'(3 + rdy_lat + rsp_lat));
            chk("ok_resp_valid", 32'(bus.out_resp_valid), 32'd1);
            chk("ok_bus_cleared", bus.out_dev_address, 32'd0);
        end
        chk("resp_data", bus.out_resp_data, exp_data);
        chk("resp_error", 32'(bus.out_resp_error), 32'(exp_err));
        ok = 1'b1;
        for (int k = 0; k < hold; k++) begin
            bus.in_req_valid = 1'b1;
            bus.in_address   = $urandom;
            @(posedge clk); #1;
            if (bus.out_resp_valid !== 1'b1 || bus.out_resp_data !== exp_data ||
                bus.out_resp_error !== exp_err || bus.out_req_ready !== 1'b0 ||
                bus.out_dev_req_valid !== '0) ok = 1'b0;
        end
        bus.in_req_valid = 1'b0;
        chk("resp_stable", 32'(ok), 32'd1);
        bus.in_resp_ready = 1'b1;
        @(posedge clk); #1;
        bus.in_resp_ready = 1'b0;
        chk("done_resp_valid", 32'(bus.out_resp_valid), 32'd0);
        chk("done_req_ready", 32'(bus.out_req_ready), 32'd1);
    endtask

    initial begin
        int n;
        idle_inputs();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_req_ready", 32'(bus.out_req_ready), 32'd1);
        chk("rst_resp_valid", 32'(bus.out_resp_valid), 32'd0);
        chk("rst_strobe", 32'(bus.out_dev_req_valid), 32'd0);
        chk("rst_resp_error", 32'(bus.out_resp_error), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        run_txn(32'h0038_0404, 1'b0, 32'd0, 4'hF, 0, 0, 32'hDEAD_BEEF, 0);
        run_txn(32'h0000_0408, 1'b1, 32'h1234_5678, 4'hF, 0, 0, 32'h5555_AAAA, 0);
        run_txn(32'h0040_0000, 1'b0, 32'd0, 4'hF, 0, 0, 32'd0, 0);
        run_txn(32'h0038_0402, 1'b0, 32'd0, 4'hF, 0, 0, 32'd0, 0);
        run_txn(32'h0037_FFFC, 1'b0, 32'd0, 4'h1, 1, 2, 32'hCAFE_F00D, 5);
        run_txn(32'h0038_0000, 1'b0, 32'd0, 4'h0, 0, 1, 32'h0BAD_C0DE, 0);
        run_txn(32'h0000_03FC, 1'b1, 32'hFFFF_0000, 4'h3, 2, 0, 32'h1111_2222, 1);

`ifdef MEM_BUS_ROUTER_TIMEOUT_EN
        bus.in_req_valid = 1'b1;
        bus.in_address   = 32'h0038_0404;
        bus.in_write_en  = 1'b0;
        @(posedge clk); #1;
        bus.in_req_valid = 1'b0;
        n = 1;
        while (bus.out_resp_valid !== 1'b1 && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        chk("tmo_latency_ok", 32'(n >= 9 && n <= 10), 32'd1);
        chk("tmo_error", 32'(bus.out_resp_error), 32'd3);
        chk("tmo_data", bus.out_resp_data, 32'd0);
        chk("tmo_strobe", 32'(bus.out_dev_req_valid), 32'd0);
        bus.in_dev_resp_valid = 4'b0010;
        bus.in_dev_read_data  = {4{32'h7777_7777}};
        @(posedge clk); #1;
        bus.in_dev_resp_valid = '0;
        chk("tmo_late_ignored", bus.out_resp_data, 32'd0);
        bus.in_resp_ready = 1'b1;
        @(posedge clk); #1;
        bus.in_resp_ready = 1'b0;
        chk("tmo_done_ready", 32'(bus.out_req_ready), 32'd1);
`else
        n = 0;
        run_txn(32'h0038_0404, 1'b0, 32'd0, 4'hF, 1000, 0, 32'h600D_600D, 0);
`endif

        bus.in_req_valid  = 1'b1;
        bus.in_address    = 32'h0038_0408;
        bus.in_write_en   = 1'b1;
        bus.in_write_data = 32'hA5A5_5A5A;
        bus.in_byte_en    = 4'h3;
        @(posedge clk); #1;
        bus.in_req_valid     = 1'b0;
        bus.in_dev_req_ready = 4'b0010;
        @(posedge clk); #1;
        bus.in_dev_req_ready = '0;
        chk("pre_rst_addr", bus.out_dev_address, 32'd2);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_req_ready", 32'(bus.out_req_ready), 32'd1);
        chk("arst_resp_valid", 32'(bus.out_resp_valid), 32'd0);
        chk("arst_strobe", 32'(bus.out_dev_req_valid), 32'd0);
        chk("arst_addr", bus.out_dev_address, 32'd0);
        chk("arst_wdata", bus.out_dev_write_data, 32'd0);
        chk("arst_we_be", {27'd0, bus.out_dev_write_en, bus.out_dev_byte_en}, 32'd0);
        idle_inputs();
        #2 rst_n = 1'b1;
        @(posedge clk); #1;

        for (int t = 0; t < 40; t++) begin
            run_txn(pick_addr(), 1'($urandom_range(0, 1)), $urandom, 4'($urandom),
                    int'($urandom_range(0, 2)), int'($urandom_range(0, 2)), $urandom,
                    int'($urandom_range(0, 2)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
